// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_32_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module seq_divider_32_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;
  logic           borrow_s;

  // rem < dvs holds on entry, so a non-negative trial always fits in WIDTH
  // bits and bit WIDTH of the trial is set only on a borrow.
  assign shifted_s = {rem, dvd_msb};
  assign trial_s   = shifted_s - {1'b0, dvs};
  assign borrow_s  = trial_s[WIDTH];
  assign q_bit     = ~borrow_s;
  assign rem_next  = borrow_s ? shifted_s[WIDTH-1:0] : trial_s[WIDTH-1:0];

endmodule

// File: rtl/seq_divider_32.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module seq_divider_32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow,
  output logic             busy
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] rem_r, dvd_r, dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             q_neg_r, r_neg_r;
  logic [WIDTH-1:0] a_abs_s, b_abs_s, rem_next_s;
  logic             q_bit_s, is_ovf_s;

  // dvd_r starts as |a| and fills up with quotient bits from the right as it shifts
  assign a_abs_s  = (signed_op && a[WIDTH-1]) ? (ZERO - a) : a;
  assign b_abs_s  = (signed_op && b[WIDTH-1]) ? (ZERO - b) : b;
  assign is_ovf_s = signed_op && (a == MIN_VAL) && (b == ALL_ONES);

  seq_divider_32_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .dvd_msb  (dvd_r[WIDTH-1]),
    .dvs      (dvs_r),
    .rem_next (rem_next_s),
    .q_bit    (q_bit_s)
  );

  // Next-state logic for the IDLE/CALC/FIX/DONE controller
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!in_valid) begin
          state_s = IDLE;
        end else if ((b == ZERO) || is_ovf_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      CALC: begin
        if (cnt_r == LAST_STEP) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX: state_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, registered handshake outputs and the iterative datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      quotient  <= ZERO;
      remainder <= ZERO;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      rem_r     <= ZERO;
      dvd_r     <= ZERO;
      dvs_r     <= ZERO;
      cnt_r     <= CNT_ZERO;
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
      busy      <= (state_s == CALC) || (state_s == FIX);
      case (state_r)
        IDLE: begin
          if (!in_valid) begin
            cnt_r <= cnt_r;
          end else if (b == ZERO) begin
            quotient  <= ALL_ONES;
            remainder <= a;
            div_zero  <= 1'b1;
            overflow  <= 1'b0;
          end else if (is_ovf_s) begin
            quotient  <= MIN_VAL;
            remainder <= ZERO;
            div_zero  <= 1'b0;
            overflow  <= 1'b1;
          end else begin
            dvd_r   <= a_abs_s;
            dvs_r   <= b_abs_s;
            rem_r   <= ZERO;
            cnt_r   <= CNT_ZERO;
            q_neg_r <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= signed_op & a[WIDTH-1];
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          quotient  <= q_neg_r ? (ZERO - dvd_r) : dvd_r;
          remainder <= r_neg_r ? (ZERO - rem_r) : rem_r;
          div_zero  <= 1'b0;
          overflow  <= 1'b0;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed self-checking bench for seq_divider_32.
module tb_seq_divider_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one request at edge E0, then count edges until out_valid shows.
  task automatic start_and_wait(input logic sgn, input logic [31:0] va, input logic [31:0] vb,
                                output int lat, output logic rdy_seen);
    @(negedge clk);
    signed_op = sgn;
    a         = va;
    b         = vb;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".ov_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".idle_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_case(input string tag, input logic sgn, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input logic eov, input int elat);
    int   lat;
    logic rdy_seen;
    start_and_wait(sgn, va, vb, lat, rdy_seen);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".rdy_low"}, {31'd0, rdy_seen}, 32'd0);
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dz"}, {31'd0, div_zero}, {31'd0, edz});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eov});
    handshake(tag);
  endtask

  initial begin
    int          lat;
    logic        rdy_seen;
    logic [31:0] q_hold;
    logic [31:0] r_hold;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    signed_op = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    #12;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.q", quotient, 32'd0);
    chk("rst.r", remainder, 32'd0);
    chk("rst.flags", {30'd0, div_zero, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 33);
    run_case("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, 33);
    run_case("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, 33);
    run_case("umax_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 33);
    run_case("u_dz",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0, 0);
    run_case("s_dz",     1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0, 0);
    run_case("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1, 0);
    run_case("u_min_m1", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0, 33);
    run_case("s_min_2",  1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 1'b0, 33);
    run_case("s-9_-4",   1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFC,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0, 33);

    // Backpressure: result held for 10 cycles while out_ready stays low
    start_and_wait(1'b0, 32'd1000, 32'd33, lat, rdy_seen);
    chk("bp.lat", lat, 33);
    q_hold = quotient;
    r_hold = remainder;
    chk("bp.q", q_hold, 32'd30);
    chk("bp.r", r_hold, 32'd10);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp.q_stable", quotient, 32'd30);
      chk("bp.r_stable", remainder, 32'd10);
      chk("bp.ov_held", {31'd0, out_valid}, 32'd1);
      chk("bp.rdy_low", {31'd0, in_ready}, 32'd0);
    end
    handshake("bp");
    chk("bp.q_kept", quotient, 32'd30);

    // Reset during CALC aborts the operation
    @(negedge clk);
    signed_op = 1'b0;
    a         = 32'd100;
    b         = 32'd7;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    chk("mid.busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_busy", {31'd0, busy}, 32'd0);
    chk("mid.rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("mid.rst_ov", {31'd0, out_valid}, 32'd0);
    chk("mid.rst_q", quotient, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
